pc_sched: RTL and testbench
===========================

PC_SCHED -- requirements
Module: pc_sched

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 recv_done  input  1  high once the instruction memory is loaded; low holds the block in BOOT.
REQ-004 irq_in  input  1  raw timer interrupt request, level.
REQ-005 pc31  input  1  current PC[31] from the fetch stage; 1 means kernel mode.
REQ-006 id_undef  input  1  the ID instruction is undefined and must raise an exception.
REQ-007 id_jump  input  1  the ID instruction is j/jal.
REQ-008 id_jr  input  1  the ID instruction is jr/jalr.
REQ-009 id_branch_taken  input  1  a branch resolved as taken in ID.
REQ-010 load_hazard  input  1  load-use hazard between EX and ID.
REQ-011 PCSrc  output  3  PC select: 000 exception, 001 interrupt, 010 jump, 011 jump-register, 100 sequential.
REQ-012 stall  output  1  freeze PC and IF/ID.
REQ-013 isJump  output  1  high when PCSrc is 010 or 011.
REQ-014 isBranch  output  1  branch redirect this cycle.
REQ-015 IRQ  output  1  interrupt pending, level.
REQ-016 irq_ack  output  1  one-cycle acknowledge pulse back to the timer.
REQ-017 exc_count  output  8  count of exceptions taken, saturating.
REQ-018 sched_state  output  2  current FSM state: 00 BOOT, 01 RUN, 10 KERNEL.

Function
REQ-019 PCSrc, stall, isJump and isBranch SHALL be combinational from the state and the current-cycle inputs (zero latency); every other output SHALL be registered.
REQ-020 In BOOT: PCSrc=100, stall=1, all redirects ignored; next state is RUN on the first edge with recv_done=1.
REQ-021 In RUN/KERNEL, the per-cycle priority SHALL be: exception (id_undef) > interrupt > load_hazard stall > jr (011) > jump (010) > branch > sequential (100).
REQ-022 Interrupt SHALL be taken (PCSrc=001) only when IRQ=1, state=RUN, pc31=0, and none of id_undef/load_hazard/id_jump/id_jr/id_branch_taken is high; otherwise it stays pending.
REQ-023 IRQ SHALL be set on a rising edge of the (optionally synchronised) irq_in and cleared on the edge where PCSrc=001 issues; irq_ack SHALL pulse on the next cycle.
REQ-024 Simultaneous irq edge and take: take wins; IRQ ends 0; the new edge is not lost (re-sets IRQ the next cycle).
REQ-025 isBranch=1 only when id_branch_taken wins arbitration; stall=1 only when load_hazard wins.
REQ-026 A PCSrc of 000 or 001 SHALL move the state to KERNEL; KERNEL SHALL return to RUN on the first edge with pc31=0.
REQ-027 Exceptions SHALL still be taken in KERNEL; interrupts SHALL be masked there.
REQ-028 exc_count SHALL increment on each PCSrc=000 and saturate at 8'hFF.
REQ-029 recv_done falling in RUN/KERNEL SHALL return the state to BOOT on the next edge; IRQ is cleared and exc_count is kept.

Reset
REQ-030 On reset: state=BOOT, IRQ=0, irq_ack=0, exc_count=0, synchroniser flops=0; consequently PCSrc=100 and stall=1.
REQ-031 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-032 PC_SCHED_IRQ_SYNC_EN defined: irq_in passes through a two-flop synchroniser before edge detection (2 extra cycles of latency).
REQ-033 PC_SCHED_IRQ_SYNC_EN undefined: irq_in is edge-detected directly, with one register stage for the edge detector only.

Structure
REQ-034 The PCSrc encodings (3'b000..3'b100) and FSM state encodings SHALL be constants in the shared cpu_pkg package.
REQ-035 One sub-module, irq_edge_sync, SHALL contain the synchroniser and rising-edge detector.

Verification
REQ-036 Reset, then recv_done=0 for 5 cycles -> PCSrc=100, stall=1, sched_state=00; recv_done=1 -> sched_state=01 on the next edge.
REQ-037 RUN with id_undef=1 and load_hazard=1 together -> PCSrc=000, stall=0, exc_count 0->1, sched_state=10.
REQ-038 IRQ pending and id_jump=1 -> PCSrc=010, isJump=1, IRQ stays 1; next cycle with no other request -> PCSrc=001, then irq_ack=1 for exactly one cycle.
REQ-039 KERNEL, pc31=1, irq_in edge -> IRQ=1 but PCSrc stays 100; pc31=0 -> RUN, interrupt taken next cycle.
REQ-040 load_hazard=1 and id_branch_taken=1 -> stall=1, isBranch=0; next cycle branch only -> isBranch=1, PCSrc=100.
REQ-041 Force 256 exceptions -> exc_count holds 8'hFF; reset asserted mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the PC scheduler.
//   PCSRC_* : PC-select encodings driven on pc_sched.PCSrc
//   sched_state_e : scheduler FSM states (exported on pc_sched.sched_state)
//   sat_inc8 : saturating 8-bit increment used by the exception counter
package cpu_pkg;

  localparam logic [2:0] PCSRC_EXC = 3'b000;
  localparam logic [2:0] PCSRC_IRQ = 3'b001;
  localparam logic [2:0] PCSRC_JMP = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_SEQ = 3'b100;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_KERNEL = 2'b10
  } sched_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the raw timer interrupt line.
//   clk, reset : clock, async active-high reset
//   irq_in     : raw level interrupt request
//   irq_rise   : high for the cycle in which a 0->1 transition is seen
// Build option: PC_SCHED_IRQ_SYNC_EN inserts a two-flop synchroniser in
// front of the detector (two extra cycles of latency). Without it the raw
// line is compared directly against a single history flop.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic irq_rise
);

`ifdef PC_SCHED_IRQ_SYNC_EN
  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= irq_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign irq_rise = s2_q & ~prev_q;
`else
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= irq_in;
  end

  assign irq_rise = irq_in & ~prev_q;
`endif

endmodule

// File: rtl/pc_sched.sv
// PC source scheduler: arbitrates exception / interrupt / hazard / jump /
// branch redirects each cycle and tracks BOOT / RUN / KERNEL mode.
//   Inputs : clk, reset (async, active high), recv_done, irq_in, pc31,
//            id_undef, id_jump, id_jr, id_branch_taken, load_hazard
//   Comb   : PCSrc[2:0], stall, isJump, isBranch (same-cycle decisions)
//   Reg    : IRQ, irq_ack, exc_count[7:0], sched_state[1:0]
// Build option: PC_SCHED_IRQ_SYNC_EN (see irq_edge_sync) synchronises irq_in.
module pc_sched
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       recv_done,
  input  logic       irq_in,
  input  logic       pc31,
  input  logic       id_undef,
  input  logic       id_jump,
  input  logic       id_jr,
  input  logic       id_branch_taken,
  input  logic       load_hazard,
  output logic [2:0] PCSrc,
  output logic       stall,
  output logic       isJump,
  output logic       isBranch,
  output logic       IRQ,
  output logic       irq_ack,
  output logic [7:0] exc_count,
  output logic [1:0] sched_state
);

  sched_state_e state_q, state_d;
  logic         irq_q, irq_d;
  logic         irq_pend_q, irq_pend_d;
  logic         irq_ack_q;
  logic [7:0]   exc_cnt_q;

  logic irq_rise;
  logic irq_ok;
  logic take_exc, take_irq;
  logic leave_run;

  irq_edge_sync u_irq_edge (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .irq_rise (irq_rise)
  );

  // Interrupt only in user-mode RUN and only in an otherwise quiet cycle,
  // so it never splits a redirect or hazard pair.
  assign irq_ok = irq_q & (state_q == ST_RUN) & ~pc31 &
                  ~(id_undef | load_hazard | id_jump | id_jr | id_branch_taken);

  always_comb begin
    state_d  = state_q;
    PCSrc    = PCSRC_SEQ;
    stall    = 1'b0;
    isBranch = 1'b0;
    take_exc = 1'b0;
    take_irq = 1'b0;
    case (state_q)
      ST_BOOT: begin
        stall = 1'b1;
        if (recv_done) state_d = ST_RUN;
      end
      default: begin
        if (id_undef) begin
          PCSrc    = PCSRC_EXC;
          take_exc = 1'b1;
        end else if (irq_ok) begin
          PCSrc    = PCSRC_IRQ;
          take_irq = 1'b1;
        end else if (load_hazard) begin
          stall = 1'b1;
        end else if (id_jr) begin
          PCSrc = PCSRC_JR;
        end else if (id_jump) begin
          PCSrc = PCSRC_JMP;
        end else if (id_branch_taken) begin
          isBranch = 1'b1;
        end

        // Losing recv_done overrides any mode change.
        if (!recv_done)                          state_d = ST_BOOT;
        else if (take_exc || take_irq)           state_d = ST_KERNEL;
        else if (state_q == ST_KERNEL && !pc31)  state_d = ST_RUN;
      end
    endcase
  end

  assign isJump    = (PCSrc == PCSRC_JMP) || (PCSrc == PCSRC_JR);
  assign leave_run = (state_q != ST_BOOT) & ~recv_done;

  // An edge arriving on the same clock as the take is parked in irq_pend_q
  // and re-raises IRQ one cycle later instead of being swallowed.
  always_comb begin
    irq_d      = (irq_q & ~take_irq) | irq_pend_q | (irq_rise & ~take_irq);
    irq_pend_d = irq_rise & take_irq;
    if (leave_run) begin
      irq_d      = 1'b0;
      irq_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      irq_q      <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_ack_q  <= 1'b0;
      exc_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_pend_q <= irq_pend_d;
      irq_ack_q  <= take_irq;
      if (take_exc) exc_cnt_q <= sat_inc8(exc_cnt_q);
    end
  end

  assign IRQ         = irq_q;
  assign irq_ack     = irq_ack_q;
  assign exc_count   = exc_cnt_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_pc_sched.sv
// Directed bench for pc_sched with a rule-level reference model that is
// compared against the DUT on every falling clock edge.
module tb_pc_sched;

  logic clk = 1'b0;
  logic reset, recv_done, irq_in, pc31, id_undef, id_jump, id_jr;
  logic id_branch_taken, load_hazard;
  logic [2:0] PCSrc;
  logic       stall, isJump, isBranch, IRQ, irq_ack;
  logic [7:0] exc_count;
  logic [1:0] sched_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sched dut (
    .clk             (clk),
    .reset           (reset),
    .recv_done       (recv_done),
    .irq_in          (irq_in),
    .pc31            (pc31),
    .id_undef        (id_undef),
    .id_jump         (id_jump),
    .id_jr           (id_jr),
    .id_branch_taken (id_branch_taken),
    .load_hazard     (load_hazard),
    .PCSrc           (PCSrc),
    .stall           (stall),
    .isJump          (isJump),
    .isBranch        (isBranch),
    .IRQ             (IRQ),
    .irq_ack         (irq_ack),
    .exc_count       (exc_count),
    .sched_state     (sched_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 BOOT, 1 RUN, 2 KERNEL
  int m_st  = 0;
  int m_cnt = 0;
  bit m_irq, m_pend, m_ack, m_prev, m_s1, m_s2;

  // Pick the highest-priority active request from an ordered list.
  function automatic void expect_comb(output logic [2:0] pcs, output logic stl,
                                      output logic br);
    bit req[6];
    int win;
    bit irq_ok;
    pcs = 3'b100; stl = 1'b0; br = 1'b0;
    if (m_st == 0) begin
      stl = 1'b1;
      return;
    end
    irq_ok = m_irq && (m_st == 1) && !pc31 &&
             !(id_undef || load_hazard || id_jump || id_jr || id_branch_taken);
    req = '{id_undef, irq_ok, load_hazard, id_jr, id_jump, id_branch_taken};
    win = 6;
    for (int i = 5; i >= 0; i--) if (req[i]) win = i;
    case (win)
      0: pcs = 3'b000;
      1: pcs = 3'b001;
      2: stl = 1'b1;
      3: pcs = 3'b011;
      4: pcs = 3'b010;
      5: br  = 1'b1;
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [2:0] e_pcs;
    logic e_stl, e_br;
    bit src, rise, take, nirq;
    if (reset) begin
      m_st = 0; m_cnt = 0; m_irq = 0; m_pend = 0; m_ack = 0;
      m_prev = 0; m_s1 = 0; m_s2 = 0;
    end
    expect_comb(e_pcs, e_stl, e_br);
    chk("m_PCSrc",    32'(PCSrc),       32'(e_pcs));
    chk("m_stall",    32'(stall),       32'(e_stl));
    chk("m_isBranch", 32'(isBranch),    32'(e_br));
    chk("m_isJump",   32'(isJump),      32'((e_pcs == 3'b010) || (e_pcs == 3'b011)));
    chk("m_IRQ",      32'(IRQ),         32'(m_irq));
    chk("m_irq_ack",  32'(irq_ack),     32'(m_ack));
    chk("m_exc_cnt",  32'(exc_count),   32'(m_cnt));
    chk("m_state",    32'(sched_state), 32'(m_st));
    if (!reset) begin
`ifdef PC_SCHED_IRQ_SYNC_EN
      src  = m_s2;
      m_s2 = m_s1;
      m_s1 = irq_in;
`else
      src  = irq_in;
`endif
      rise   = src && !m_prev;
      m_prev = src;
      take   = (e_pcs == 3'b001);
      m_ack  = take;
      if (e_pcs == 3'b000 && m_st != 0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (m_st != 0 && !recv_done) begin
        m_st = 0; m_irq = 0; m_pend = 0;
      end else begin
        nirq   = (m_irq && !take) || m_pend || (rise && !take);
        m_pend = rise && take;
        m_irq  = nirq;
        if (m_st == 0)                        m_st = recv_done ? 1 : 0;
        else if (take || e_pcs == 3'b000)     m_st = 2;
        else if (m_st == 2 && !pc31)          m_st = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; recv_done = 0; irq_in = 0; pc31 = 0; id_undef = 0;
    id_jump = 0; id_jr = 0; id_branch_taken = 0; load_hazard = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_state", 32'(sched_state), 0);
    chk("rst_pcsrc", 32'(PCSrc), 4);
    chk("rst_stall", 32'(stall), 1);
    chk("rst_irq",   32'(IRQ), 0);
    chk("rst_cnt",   32'(exc_count), 0);

    // BOOT holds until recv_done
    repeat (5) step();
    chk("boot_hold",  32'(sched_state), 0);
    chk("boot_stall", 32'(stall), 1);
    recv_done = 1; step();
    chk("boot_to_run", 32'(sched_state), 1);

    // exception beats load hazard
    id_undef = 1; load_hazard = 1; #1;
    chk("exc_pcsrc", 32'(PCSrc), 0);
    chk("exc_stall", 32'(stall), 0);
    step(); id_undef = 0; load_hazard = 0;
    chk("exc_cnt",    32'(exc_count), 1);
    chk("exc_kernel", 32'(sched_state), 2);
    step();
    chk("kern_ret", 32'(sched_state), 1);

    // pending IRQ deferred by jump, then taken
    irq_in = 1; step();
    chk("irq_set", 32'(IRQ), 1);
    id_jump = 1; #1;
    chk("jmp_pcsrc",  32'(PCSrc), 2);
    chk("jmp_isjump", 32'(isJump), 1);
    step(); id_jump = 0; #1;
    chk("irq_held", 32'(IRQ), 1);
    chk("irq_take", 32'(PCSrc), 1);
    step();
    chk("ack_hi",     32'(irq_ack), 1);
    chk("irq_clr",    32'(IRQ), 0);
    chk("irq_kernel", 32'(sched_state), 2);
    step();
    chk("ack_lo",    32'(irq_ack), 0);
    chk("kern_ret2", 32'(sched_state), 1);

    // interrupt masked in KERNEL while pc31=1
    irq_in = 0; id_undef = 1; step();
    id_undef = 0; pc31 = 1; irq_in = 1; step();
    chk("kirq_set", 32'(IRQ), 1);
    #1 chk("kirq_mask", 32'(PCSrc), 4);
    chk("kirq_state", 32'(sched_state), 2);
    step();
    chk("kstay", 32'(sched_state), 2);
    pc31 = 0; #1;
    chk("kmask2", 32'(PCSrc), 4);
    step();
    chk("k2run", 32'(sched_state), 1);
    #1 chk("kirq_take", 32'(PCSrc), 1);
    step();
    chk("kack", 32'(irq_ack), 1);
    step();

    // hazard beats branch, then branch alone
    load_hazard = 1; id_branch_taken = 1; #1;
    chk("hz_stall",  32'(stall), 1);
    chk("hz_branch", 32'(isBranch), 0);
    chk("hz_pcsrc",  32'(PCSrc), 4);
    step(); load_hazard = 0; #1;
    chk("br_is",    32'(isBranch), 1);
    chk("br_pcsrc", 32'(PCSrc), 4);
    chk("br_stall", 32'(stall), 0);
    step(); id_branch_taken = 0; id_jr = 1; id_jump = 1; #1;
    chk("jr_pcsrc",  32'(PCSrc), 3);
    chk("jr_isjump", 32'(isJump), 1);
    step(); id_jr = 0; id_jump = 0;

    // new edge on the same clock as the take is kept
    irq_in = 0; step();
    irq_in = 1; step();
    id_jump = 1; irq_in = 0; step();
    id_jump = 0; irq_in = 1; #1;
    chk("simul_take", 32'(PCSrc), 1);
    step();
    chk("simul_irq0", 32'(IRQ), 0);
    chk("simul_ack",  32'(irq_ack), 1);
    step();
    chk("simul_rearm", 32'(IRQ), 1);

    // recv_done drop returns to BOOT, counter kept
    recv_done = 0; step();
    chk("rd_boot", 32'(sched_state), 0);
    chk("rd_irq",  32'(IRQ), 0);
    chk("rd_cnt",  32'(exc_count), 2);
    recv_done = 1; step();

    // saturation, then asynchronous reset mid-cycle
    id_undef = 1;
    repeat (260) step();
    chk("sat", 32'(exc_count), 255);
    #2 reset = 1;
    #1;
    chk("arst_state", 32'(sched_state), 0);
    chk("arst_cnt",   32'(exc_count), 0);
    chk("arst_pcsrc", 32'(PCSrc), 4);
    chk("arst_stall", 32'(stall), 1);
    chk("arst_irq",   32'(IRQ), 0);
    chk("arst_ack",   32'(irq_ack), 0);
    step(); step();
    reset = 0; id_undef = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
